// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//
// Melody sequencer feeding the tone/sound stage. Steps through a programmable
// table of {note, beats} entries and drives a 5-bit one-hot tone select.
// Every note is held for beats*BEAT_CYCLES clocks. A silent gap of GAP_CYCLES
// clocks follows each note. A one-cycle FETCH then reads the next entry.
//
// Ports:
//   clk       system clock
//   reset_n   synchronous active-low reset (table contents are kept)
//   start     level-sampled; begins playback at entry 0 when idle
//   stop      aborts playback (priority over everything else)
//   pause     freezes playback and silences output while high (not in IDLE)
//   loop      at end of song, restart from entry 0 instead of finishing
//   wr_en     table write strobe (accepted only while idle)
//   wr_addr   table write index
//   wr_note   note select, one-hot tone or 0 for rest
//   wr_beats  duration in beats, 0 marks end of song
//   songD     one-hot tone select to the sound stage, 0 = silence
//   busy      high in every non-IDLE state
//   done      one-cycle pulse on natural end of song
//   step      index of the current entry
// -----------------------------------------------------------------------------
module note_sequencer #(
    parameter int BEAT_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 2500000,
    parameter int SONG_LEN    = 16,
    localparam int AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          loop,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [4:0]    wr_note,
    input  logic [3:0]    wr_beats,
    output logic [4:0]    songD,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step
);

    // The cycle counter also times the gap, which is legal because
    // GAP_CYCLES < BEAT_CYCLES, so the gap count always fits.
    localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

    localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [AW-1:0] STEP_LAST = AW'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // True when the note is a single tone or a rest. Any other pattern
    // would select several tones at once and is played as silence.
    function automatic logic note_ok(input logic [4:0] n);
        return ((n & (n - 5'd1)) == 5'd0);
    endfunction

    logic [8:0]    mem_q [SONG_LEN];
    logic [8:0]    rd_q;

    state_t        state_q, state_d;
    logic [AW-1:0] step_q, step_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [3:0]    beat_q, beat_d;
    logic [4:0]    note_q, note_d;
    logic [4:0]    songd_q, songd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          hold_s;

    logic [4:0]    rd_note_s;
    logic [3:0]    rd_beats_s;

    assign rd_note_s  = rd_q[8:4];
    assign rd_beats_s = rd_q[3:0];

    // Next-state, counter and output logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cyc_d   = cyc_q;
        beat_d  = beat_q;
        note_d  = note_q;
        done_d  = 1'b0;
        hold_s  = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            step_d  = '0;
            cyc_d   = '0;
            beat_d  = 4'd0;
        end else if (pause && (state_q != S_IDLE)) begin
            hold_s = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        step_d  = '0;
                        cyc_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (rd_beats_s == 4'd0) begin
                        if (loop) begin
                            step_d  = '0;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = S_PLAY;
                        cyc_d   = '0;
                        beat_d  = rd_beats_s;
                        note_d  = note_ok(rd_note_s) ? rd_note_s : 5'd0;
                    end
                end
                S_PLAY: begin
                    if (cyc_q == BEAT_LAST) begin
                        cyc_d = '0;
                        if (beat_q == 4'd1) begin
                            state_d = S_GAP;
                        end else begin
                            beat_d = beat_q - 4'd1;
                        end
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cyc_q == GAP_LAST) begin
                        cyc_d = '0;
                        if (step_q == STEP_LAST) begin
                            if (loop) begin
                                step_d  = '0;
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            step_d  = step_q + AW'(1);
                            state_d = S_FETCH;
                        end
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        songd_d = ((state_d == S_PLAY) && !hold_s) ? note_d : 5'd0;
        busy_d  = (state_d != S_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            cyc_q   <= '0;
            beat_q  <= 4'd0;
            note_q  <= 5'd0;
            songd_q <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cyc_q   <= cyc_d;
            beat_q  <= beat_d;
            note_q  <= note_d;
            songd_q <= songd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Note table. It is written only while idle and is never cleared by reset.
    // The read address is the next step, so the entry for the step being entered
    // is ready in rd_q during the FETCH cycle.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == S_IDLE)) begin
            mem_q[wr_addr] <= {wr_note, wr_beats};
        end
        rd_q <= mem_q[step_d];
    end

    assign songD = songd_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign step  = step_q;

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//
// Self-checking bench for note_sequencer with BEAT_CYCLES=4, GAP_CYCLES=2 and
// SONG_LEN=4. Each scenario pushes the expected {songD, busy, done, step} for
// every clock onto a scoreboard queue. It then drives the stimulus and compares
// the DUT state on each falling edge against the popped entry.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, stop, pause, loop, wr_en;
    logic [1:0] wr_addr;
    logic [4:0] wr_note;
    logic [3:0] wr_beats;
    logic [4:0] songD;
    logic       busy, done;
    logic [1:0] step;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] sb[$];
    logic [8:0] e;
    logic [8:0] obs_s;

    assign obs_s = {songD, busy, done, step};

    always #5 clk = ~clk;

    note_sequencer #(
        .BEAT_CYCLES(4),
        .GAP_CYCLES (2),
        .SONG_LEN   (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .loop    (loop),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_note (wr_note),
        .wr_beats(wr_beats),
        .songD   (songD),
        .busy    (busy),
        .done    (done),
        .step    (step)
    );

    task automatic push(input logic [4:0] s, input logic b, input logic d,
                        input logic [1:0] st, input int n);
        repeat (n) sb.push_back({s, b, d, st});
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [4:0] n,
                               input logic [3:0] bt);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_note = n; wr_beats = bt;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_basic();
        write_entry(2'd0, 5'b00001, 4'd2);
        write_entry(2'd1, 5'b00100, 4'd1);
        write_entry(2'd2, 5'b00000, 4'd1);
        write_entry(2'd3, 5'b10101, 4'd0);
    endtask

    // Expected trace of the basic song, starting with the FETCH cycle.
    task automatic push_basic();
        push(5'b00000, 1'b1, 1'b0, 2'd0, 1);
        push(5'b00001, 1'b1, 1'b0, 2'd0, 8);
        push(5'b00000, 1'b1, 1'b0, 2'd0, 2);
        push(5'b00000, 1'b1, 1'b0, 2'd1, 1);
        push(5'b00100, 1'b1, 1'b0, 2'd1, 4);
        push(5'b00000, 1'b1, 1'b0, 2'd1, 2);
        push(5'b00000, 1'b1, 1'b0, 2'd2, 5);
        push(5'b00000, 1'b1, 1'b0, 2'd2, 2);
        push(5'b00000, 1'b1, 1'b0, 2'd3, 1);
        push(5'b00000, 1'b0, 1'b1, 2'd3, 1);
        push(5'b00000, 1'b0, 1'b0, 2'd3, 1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) reset_n = 1'b1;
            if (obs_s !== 9'b0) begin
                miscompares++;
                $display("FAIL reset idx %0d: got %b want %b", i, obs_s, 9'b0);
            end
            vectors++;
        end
    endtask

    task automatic test_basic();
        int n;
        load_basic();
        sb.delete();
        push_basic();
        n = sb.size();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            e = sb.pop_front();
            if (obs_s !== e) begin
                miscompares++;
                $display("FAIL basic idx %0d: got %b want %b", i, obs_s, e);
            end
            vectors++;
        end
    endtask

    task automatic test_stop();
        int n;
        sb.delete();
        push(5'b00000, 1'b1, 1'b0, 2'd0, 1);
        push(5'b00001, 1'b1, 1'b0, 2'd0, 3);
        push(5'b00000, 1'b0, 1'b0, 2'd0, 3);
        push(5'b00000, 1'b1, 1'b0, 2'd0, 1);
        push(5'b00001, 1'b1, 1'b0, 2'd0, 2);
        push(5'b00000, 1'b0, 1'b0, 2'd0, 2);
        n = sb.size();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0 || i == 7) start = 1'b0;
            if (i == 3 || i == 9) stop = 1'b1;
            if (i == 4 || i == 10) stop = 1'b0;
            if (i == 6) start = 1'b1;
            e = sb.pop_front();
            if (obs_s !== e) begin
                miscompares++;
                $display("FAIL stop idx %0d: got %b want %b", i, obs_s, e);
            end
            vectors++;
        end
    endtask

    task automatic test_pause();
        int n;
        write_entry(2'd0, 5'b00010, 4'd1);
        write_entry(2'd1, 5'b00000, 4'd0);
        sb.delete();
        push(5'b00000, 1'b1, 1'b0, 2'd0, 1);
        push(5'b00010, 1'b1, 1'b0, 2'd0, 2);
        push(5'b00000, 1'b1, 1'b0, 2'd0, 5);
        push(5'b00010, 1'b1, 1'b0, 2'd0, 2);
        push(5'b00000, 1'b1, 1'b0, 2'd0, 2);
        push(5'b00000, 1'b1, 1'b0, 2'd1, 1);
        push(5'b00000, 1'b0, 1'b1, 2'd1, 1);
        push(5'b00000, 1'b0, 1'b0, 2'd1, 1);
        n = sb.size();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 2) pause = 1'b1;
            if (i == 7) pause = 1'b0;
            e = sb.pop_front();
            if (obs_s !== e) begin
                miscompares++;
                $display("FAIL pause idx %0d: got %b want %b", i, obs_s, e);
            end
            vectors++;
        end
    endtask

    task automatic test_loop();
        int n;
        logic [4:0] nt;
        for (int k = 0; k < 4; k++) begin
            nt = 5'b00001 << k;
            write_entry(2'(k), nt, 4'd1);
        end
        sb.delete();
        for (int k = 0; k < 4; k++) begin
            nt = 5'b00001 << k;
            push(5'b00000, 1'b1, 1'b0, 2'(k), 1);
            push(nt,       1'b1, 1'b0, 2'(k), 4);
            push(5'b00000, 1'b1, 1'b0, 2'(k), 2);
        end
        push(5'b00000, 1'b1, 1'b0, 2'd0, 1);
        push(5'b00001, 1'b1, 1'b0, 2'd0, 4);
        push(5'b00000, 1'b0, 1'b0, 2'd0, 2);
        n = sb.size();
        loop = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 32) stop = 1'b1;
            if (i == 33) stop = 1'b0;
            e = sb.pop_front();
            if (obs_s !== e) begin
                miscompares++;
                $display("FAIL loop idx %0d: got %b want %b", i, obs_s, e);
            end
            vectors++;
        end
        loop = 1'b0;
    endtask

    task automatic test_corner();
        int n;
        // End marker in entry 0: done two cycles after start, never audible.
        write_entry(2'd0, 5'b00001, 4'd0);
        sb.delete();
        push(5'b00000, 1'b1, 1'b0, 2'd0, 1);
        push(5'b00000, 1'b0, 1'b1, 2'd0, 1);
        push(5'b00000, 1'b0, 1'b0, 2'd0, 1);
        n = sb.size();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            e = sb.pop_front();
            if (obs_s !== e) begin
                miscompares++;
                $display("FAIL empty_song idx %0d: got %b want %b", i, obs_s, e);
            end
            vectors++;
        end

        // Invalid note plays as silence. A write while busy is dropped, so the
        // second run must see entry 1 still marking end of song.
        write_entry(2'd0, 5'b00011, 4'd1);
        write_entry(2'd1, 5'b00000, 4'd0);
        for (int run = 0; run < 2; run++) begin
            sb.delete();
            push(5'b00000, 1'b1, 1'b0, 2'd0, 7);
            push(5'b00000, 1'b1, 1'b0, 2'd1, 1);
            push(5'b00000, 1'b0, 1'b1, 2'd1, 1);
            push(5'b00000, 1'b0, 1'b0, 2'd1, 1);
            n = sb.size();
            @(negedge clk);
            start = 1'b1;
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                if (i == 0) start = 1'b0;
                if (i == 2 && run == 0) begin
                    wr_en = 1'b1; wr_addr = 2'd1; wr_note = 5'b00001; wr_beats = 4'd1;
                end
                if (i == 3) wr_en = 1'b0;
                e = sb.pop_front();
                if (obs_s !== e) begin
                    miscompares++;
                    $display("FAIL bad_note run %0d idx %0d: got %b want %b", run, i, obs_s, e);
                end
                vectors++;
            end
        end

        // start together with stop in IDLE: stays idle.
        sb.delete();
        push(5'b00000, 1'b0, 1'b0, 2'd0, 3);
        n = sb.size();
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                stop  = 1'b0;
            end
            e = sb.pop_front();
            if (obs_s !== e) begin
                miscompares++;
                $display("FAIL start_stop idx %0d: got %b want %b", i, obs_s, e);
            end
            vectors++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        load_basic();
        sb.delete();
        push(5'b00000, 1'b1, 1'b0, 2'd0, 1);
        push(5'b00001, 1'b1, 1'b0, 2'd0, 3);
        push(5'b00000, 1'b0, 1'b0, 2'd0, 2);
        push_basic();
        n = sb.size();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0 || i == 6) start = 1'b0;
            if (i == 3) reset_n = 1'b0;
            if (i == 4) reset_n = 1'b1;
            if (i == 5) start = 1'b1;
            e = sb.pop_front();
            if (obs_s !== e) begin
                miscompares++;
                $display("FAIL reset_mid idx %0d: got %b want %b", i, obs_s, e);
            end
            vectors++;
        end
    endtask

    initial begin
        start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
        wr_en = 1'b0; wr_addr = 2'd0; wr_note = 5'd0; wr_beats = 4'd0;
        reset_n = 1'b0;
        test_reset();
        test_basic();
        test_stop();
        test_pause();
        test_loop();
        test_corner();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
